// File: rtl/circle_raster_engine.sv
// Midpoint-circle / pixel / clear command engine over a 1-bit pixel RAM, commanded by a multicycle custom instruction.
// Latency: circle 2+9N cycles, pixel 2, clear 2^ADDR_W+1, illegal 1; the MM port stalls via waitrequest whenever the FSM is not IDLE.
module circle_raster_engine #(
  parameter int COORD_W = 9,
  parameter int ADDR_W  = 2 * COORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       A,
  input  logic [31:0]       B,
  output logic [31:0]       result,
  output logic              done,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic              readdatavalid
);

  localparam int PW   = COORD_W + 1;
  localparam int DW   = COORD_W + 3;
  localparam int NPIX = 1 << ADDR_W;
  localparam logic signed [PW-1:0] P_ONE = 1;
  localparam logic signed [DW-1:0] D_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_PLOT, S_STEP, S_PIX, S_CLR, S_FIN} state_t;

  state_t                 r_state;
  logic [COORD_W-1:0]     r_cx, r_cy, r_rad;
  logic signed [PW-1:0]   r_x, r_y;
  logic signed [DW-1:0]   r_d;
  logic [2:0]             r_k;
  logic [ADDR_W-1:0]      r_clr_addr;
  logic [31:0]            r_cnt;
  logic                   r_ram [NPIX];

  logic                   w_busy;
  logic [COORD_W-1:0]     w_xs, w_ys, w_px, w_py;
  logic                   w_we, w_wdat, w_fsm_we;
  logic [ADDR_W-1:0]      w_waddr;
  logic [31:0]            w_cnt_nxt;
  logic signed [PW-1:0]   w_x_nxt, w_y_nxt;
  logic signed [DW-1:0]   w_xd, w_yd, w_d_nxt, w_d_init;
  logic                   w_cont;
  logic                   w_unused;

  assign w_busy      = (r_state != S_IDLE);
  assign waitrequest = w_busy;
  assign w_unused    = ^{A[31:2*COORD_W], B[29:COORD_W], writedata[31:1]};

  assign w_xs = r_x[COORD_W-1:0];
  assign w_ys = r_y[COORD_W-1:0];

  // Eight-way symmetric octant points; sums wrap naturally at COORD_W bits.
  always_comb begin
    w_px = r_cx;
    w_py = r_cy;
    case (r_k)
      3'd0: begin w_px = r_cx + w_xs; w_py = r_cy + w_ys; end
      3'd1: begin w_px = r_cx + w_xs; w_py = r_cy - w_ys; end
      3'd2: begin w_px = r_cx - w_xs; w_py = r_cy + w_ys; end
      3'd3: begin w_px = r_cx - w_xs; w_py = r_cy - w_ys; end
      3'd4: begin w_px = r_cx + w_ys; w_py = r_cy + w_xs; end
      3'd5: begin w_px = r_cx + w_ys; w_py = r_cy - w_xs; end
      3'd6: begin w_px = r_cx - w_ys; w_py = r_cy + w_xs; end
      default: begin w_px = r_cx - w_ys; w_py = r_cy - w_xs; end
    endcase
  end

  // Single RAM write port: the MM master owns it in IDLE, the FSM otherwise.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = address;
    w_wdat  = writedata[0];
    case (r_state)
      S_IDLE: w_we = write;
      S_PLOT: begin w_we = 1'b1; w_waddr = {w_py, w_px}; w_wdat = 1'b1; end
      S_PIX:  begin w_we = 1'b1; w_waddr = {r_cy, r_cx}; w_wdat = 1'b1; end
      S_CLR:  begin w_we = 1'b1; w_waddr = r_clr_addr;   w_wdat = 1'b0; end
      default: ;
    endcase
  end

  assign w_fsm_we  = w_we & w_busy;
  assign w_cnt_nxt = r_cnt + {31'b0, w_fsm_we};

  assign w_y_nxt  = r_y + P_ONE;
  assign w_x_nxt  = r_d[DW-1] ? r_x : (r_x - P_ONE);
  assign w_yd     = {{(DW-PW){w_y_nxt[PW-1]}}, w_y_nxt};
  assign w_xd     = {{(DW-PW){w_x_nxt[PW-1]}}, w_x_nxt};
  assign w_d_nxt  = r_d[DW-1] ? (r_d + (w_yd <<< 1) + D_ONE)
                              : (r_d + ((w_yd - w_xd) <<< 1) + D_ONE);
  assign w_d_init = D_ONE - {{(DW-COORD_W){1'b0}}, r_rad};
  assign w_cont   = (w_x_nxt >= w_y_nxt);

  always_ff @(posedge clk) begin
    if (w_we) r_ram[w_waddr] <= w_wdat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      result        <= '0;
      done          <= 1'b0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      r_cx          <= '0;
      r_cy          <= '0;
      r_rad         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_d           <= '0;
      r_k           <= '0;
      r_clr_addr    <= '0;
      r_cnt         <= '0;
    end else begin
      done          <= 1'b0;
      readdatavalid <= 1'b0;
      readdata      <= '0;
      r_cnt         <= w_cnt_nxt;
      case (r_state)
        S_IDLE: begin
          if (read && !write) begin
            readdatavalid <= 1'b1;
            readdata      <= {31'b0, r_ram[address]};
          end
          if (start) begin
            r_cx       <= A[COORD_W-1:0];
            r_cy       <= A[2*COORD_W-1:COORD_W];
            r_rad      <= B[COORD_W-1:0];
            r_cnt      <= '0;
            r_k        <= '0;
            r_clr_addr <= '0;
            case (B[31:30])
              2'b00:   r_state <= S_INIT;
              2'b01:   r_state <= S_PIX;
              2'b10:   r_state <= S_CLR;
              default: begin r_state <= S_FIN; done <= 1'b1; result <= '1; end
            endcase
          end
        end
        S_INIT: begin
          r_x     <= {1'b0, r_rad};
          r_y     <= '0;
          r_d     <= w_d_init;
          r_state <= S_PLOT;
        end
        S_PLOT: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) r_state <= S_STEP;
        end
        S_STEP: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_d <= w_d_nxt;
          if (w_cont) begin
            r_state <= S_PLOT;
          end else begin
            r_state <= S_FIN;
            done    <= 1'b1;
            result  <= r_cnt;
          end
        end
        S_PIX: begin
          r_state <= S_FIN;
          done    <= 1'b1;
          result  <= w_cnt_nxt;
        end
        S_CLR: begin
          r_clr_addr <= r_clr_addr + ADDR_W'(1);
          if (r_clr_addr == '1) begin
            r_state <= S_FIN;
            done    <= 1'b1;
            result  <= w_cnt_nxt;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_raster_engine.sv
// Bench for circle_raster_engine on a 128x128 raster so full clears stay short;
// a plain-arithmetic midpoint model plus a pixel array predicts results, latencies and RAM contents.
module tb_circle_raster_engine;
  localparam int CW = 7;
  localparam int AW = 2 * CW;
  localparam int NP = 1 << AW;
  localparam int M  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   A = '0;
  logic [31:0]   B = '0;
  logic [31:0]   result;
  logic          done;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic          readdatavalid;

  int checks = 0;
  int errors = 0;
  bit model [NP];

  circle_raster_engine #(.COORD_W(CW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .result(result), .done(done), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_a(int cx, int cy);
    logic [31:0] v;
    v = '0;
    v[CW-1:0]    = cx[CW-1:0];
    v[2*CW-1:CW] = cy[CW-1:0];
    return v;
  endfunction

  function automatic logic [31:0] mk_b(int op, int r);
    logic [31:0] v;
    v = '0;
    v[CW-1:0] = r[CW-1:0];
    v[31:30]  = op[1:0];
    return v;
  endfunction

  function automatic int pidx(int x, int y);
    return ((y & M) << CW) | (x & M);
  endfunction

  // Reference midpoint circle: marks the model and returns the number of writes.
  function automatic int model_circle(int cx, int cy, int r);
    int x = r;
    int y = 0;
    int d = 1 - r;
    int n = 0;
    do begin
      model[pidx(cx + x, cy + y)] = 1'b1;
      model[pidx(cx + x, cy - y)] = 1'b1;
      model[pidx(cx - x, cy + y)] = 1'b1;
      model[pidx(cx - x, cy - y)] = 1'b1;
      model[pidx(cx + y, cy + x)] = 1'b1;
      model[pidx(cx + y, cy - x)] = 1'b1;
      model[pidx(cx - y, cy + x)] = 1'b1;
      model[pidx(cx - y, cy - x)] = 1'b1;
      n += 8;
      y++;
      if (d < 0) d += 2 * y + 1;
      else begin x--; d += 2 * (y - x) + 1; end
    end while (x >= y);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit got);
    tick();
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    got = 1'b0;
    while (lat < NP + 50) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      tick();
      lat++;
    end
    res = result;
  endtask

  task automatic mm_read(input int x, input int y, output logic [31:0] data, output logic rdv);
    int n = 0;
    logic w;
    address = pidx(x, y);
    read = 1'b1;
    do begin w = waitrequest; tick(); n++; end while (w !== 1'b0 && n < 40000);
    read = 1'b0;
    data = readdata;
    rdv  = readdatavalid;
  endtask

  task automatic mm_write(input int x, input int y, input bit v);
    int n = 0;
    logic w;
    address = pidx(x, y);
    writedata = {31'b0, v};
    write = 1'b1;
    do begin w = waitrequest; tick(); n++; end while (w !== 1'b0 && n < 40000);
    write = 1'b0;
  endtask

  // Pipelined square readback around (cx,cy); returns the number of pixels disagreeing with the model.
  task automatic region_bad(input int cx, input int cy, input int h, output int bad);
    bad = 0;
    for (int dy = -h; dy <= h; dy++) begin
      for (int dx = -h; dx <= h; dx++) begin
        address = pidx(cx + dx, cy + dy);
        read = 1'b1;
        tick();
        if (readdatavalid !== 1'b1 || readdata !== {31'b0, model[pidx(cx + dx, cy + dy)]}) bad++;
      end
    end
    read = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitrequest got %b want 0", waitrequest); end
    checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", readdatavalid); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    logic [31:0] res;
    int lat, bad;
    bit got;
    run_cmd(mk_a(0, 0), mk_b(2, 0), res, lat, got);
    for (int i = 0; i < NP; i++) model[i] = 1'b0;
    checks++; if (!got || lat != NP + 1) begin errors++; $display("FAIL clear_latency got %0d want %0d", lat, NP + 1); end
    checks++; if (res !== 32'(NP)) begin errors++; $display("FAIL clear_result got %0d want %0d", res, NP); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clear_done_width got %b want 0", done); end
    bad = 0;
    for (int i = 0; i < NP; i++) begin
      address = i[AW-1:0];
      read = 1'b1;
      tick();
      if (readdatavalid !== 1'b1 || readdata !== 32'h0) bad++;
    end
    read = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_readback got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_mm_read();
    logic [31:0] d;
    logic v;
    tick();
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL mmrd_wait got %b want 0", waitrequest); end
    mm_read(5, 5, d, v);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL mmrd_rdv got %b want 1", v); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mmrd_data got %h want 0", d); end
    tick();
    checks++; if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      errors++; $display("FAIL mmrd_rdv_pulse got %b/%h want 0/0", readdatavalid, readdata);
    end
  endtask

  task automatic test_circle_r3();
    logic [31:0] res, d;
    logic v;
    int lat, bad, n;
    bit got;
    n = model_circle(100, 100, 3);
    run_cmd(mk_a(100, 100), mk_b(0, 3), res, lat, got);
    checks++; if (!got || lat != 29) begin errors++; $display("FAIL r3_latency got %0d want 29", lat); end
    checks++; if (res !== 32'd24 || n != 24) begin errors++; $display("FAIL r3_result got %0d want 24 (model %0d)", res, n); end
    repeat (4) tick();
    checks++; if (result !== 32'd24) begin errors++; $display("FAIL r3_result_hold got %0d want 24", result); end
    mm_read(102, 102, d, v);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL r3_pix_102_102 got %h want 1", d); end
    mm_read(100, 100, d, v);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL r3_center got %h want 0", d); end
    region_bad(100, 100, 4, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL r3_region got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_wrap();
    logic [31:0] res, d;
    logic v;
    int lat, n;
    bit got;
    int px[4] = '{M, 1, 0, 0};
    int py[4] = '{0, 0, M, 1};
    n = model_circle(0, 0, 1);
    run_cmd(mk_a(0, 0), mk_b(0, 1), res, lat, got);
    checks++; if (!got || lat != 11) begin errors++; $display("FAIL wrap_latency got %0d want 11", lat); end
    checks++; if (res !== 32'd8) begin errors++; $display("FAIL wrap_result got %0d want 8", res); end
    for (int i = 0; i < 4; i++) begin
      mm_read(px[i], py[i], d, v);
      checks++; if (d !== 32'd1) begin errors++; $display("FAIL wrap_pix_%0d_%0d got %h want 1", px[i], py[i], d); end
    end
    n = model_circle(60, 60, 0);
    run_cmd(mk_a(60, 60), mk_b(0, 0), res, lat, got);
    checks++; if (!got || lat != 11 || res !== 32'd8) begin
      errors++; $display("FAIL r0_cmd got lat %0d res %0d want 11/8", lat, res);
    end
    mm_read(60, 60, d, v);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL r0_pix got %h want 1", d); end
  endtask

  task automatic test_mm_during_op();
    logic [31:0] d;
    logic v;
    int n, lat, done_lat, wr_lat, ndone, extra;
    n = model_circle(30, 30, 5);
    tick();
    A = mk_a(30, 30); B = mk_b(0, 5); start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; ndone = 0; done_lat = -1; wr_lat = -1;
    address = pidx(2, 2); writedata = 32'd1; write = 1'b1;
    while (lat < 2000) begin
      start = 1'b0;
      if (lat == 3) begin A = mk_a(0, 0); B = mk_b(2, 0); start = 1'b1; end
      if (done === 1'b1) begin
        ndone++; done_lat = lat;
        A = mk_a(3, 3); B = mk_b(1, 0); start = 1'b1;
      end else if (waitrequest === 1'b0) begin
        wr_lat = lat;
        break;
      end
      tick();
      lat++;
    end
    tick();
    write = 1'b0; start = 1'b0;
    model[pidx(2, 2)] = 1'b1;
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", ndone); end
    checks++; if (done_lat != 2 + 9 * (n / 8)) begin errors++; $display("FAIL busy_done_lat got %0d want %0d", done_lat, 2 + 9 * (n / 8)); end
    checks++; if (wr_lat != done_lat + 1) begin errors++; $display("FAIL busy_write_accept got %0d want %0d", wr_lat, done_lat + 1); end
    extra = 0;
    repeat (30) begin tick(); if (done === 1'b1) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_extra_done got %0d want 0", extra); end
    mm_read(2, 2, d, v);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL busy_write_pix got %h want 1", d); end
    mm_read(3, 3, d, v);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL fin_start_ignored got %h want 0", d); end
    mm_read(35, 30, d, v);
    checks++; if (d !== {31'b0, model[pidx(35, 30)]}) begin errors++; $display("FAIL busy_circle_pix got %h want %0d", d, model[pidx(35, 30)]); end
  endtask

  task automatic test_illegal();
    logic [31:0] res, d;
    logic v;
    int lat;
    bit got;
    run_cmd(mk_a(10, 10), mk_b(3, 4), res, lat, got);
    checks++; if (!got || lat != 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL illegal_result got %h want ffffffff", res); end
    mm_read(10, 10, d, v);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL illegal_ram_center got %h want 0", d); end
    mm_read(103, 100, d, v);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL illegal_ram_old got %h want 1", d); end
  endtask

  task automatic test_random();
    logic [31:0] res, d, exp_res;
    logic v;
    int lat, exp_lat, bad, op, cx, cy, r, n, x, y;
    bit got, bv;
    int ops[4] = '{0, 0, 1, 3};
    for (int it = 0; it < 10; it++) begin
      op = ops[$urandom_range(0, 3)];
      cx = $urandom_range(0, M);
      cy = $urandom_range(0, M);
      r  = $urandom_range(0, 12);
      if (op == 0) begin
        n = model_circle(cx, cy, r);
        exp_res = 32'(n); exp_lat = 2 + 9 * (n / 8);
      end else if (op == 1) begin
        model[pidx(cx, cy)] = 1'b1;
        exp_res = 32'd1; exp_lat = 2;
      end else begin
        exp_res = 32'hFFFF_FFFF; exp_lat = 1;
      end
      run_cmd(mk_a(cx, cy), mk_b(op, r), res, lat, got);
      checks++; if (!got || lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency op %0d got %0d want %0d", it, op, lat, exp_lat); end
      checks++; if (res !== exp_res) begin errors++; $display("FAIL rand%0d_result op %0d got %h want %h", it, op, res, exp_res); end
      tick();
      region_bad(cx, cy, r + 1, bad);
      checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_region got %0d bad pixels want 0", it, bad); end
      x = $urandom_range(0, M);
      y = $urandom_range(0, M);
      bv = 1'($urandom_range(0, 1));
      mm_write(x, y, bv);
      model[pidx(x, y)] = bv;
      mm_read(x, y, d, v);
      checks++; if (v !== 1'b1 || d !== {31'b0, bv}) begin errors++; $display("FAIL rand%0d_mm got %h/%b want %0d/1", it, d, v, bv); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, d;
    logic v;
    int lat, extra, wr_bad;
    bit got;
    tick();
    A = mk_a(50, 50); B = mk_b(0, 10); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    #1;
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL rstmid_wait got %b want 0", waitrequest); end
    checks++; if (done !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL rstmid_outputs got %b/%h want 0/0", done, result); end
    tick(); tick();
    reset = 1'b0;
    extra = 0; wr_bad = 0;
    repeat (300) begin
      tick();
      if (done === 1'b1) extra++;
      if (waitrequest !== 1'b0) wr_bad++;
    end
    checks++; if (extra != 0 || wr_bad != 0) begin errors++; $display("FAIL rstmid_no_done got %0d dones %0d busy want 0/0", extra, wr_bad); end
    run_cmd(mk_a(7, 9), mk_b(1, 0), res, lat, got);
    checks++; if (!got || lat != 2) begin errors++; $display("FAIL pix_latency got %0d want 2", lat); end
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL pix_result got %0d want 1", res); end
    mm_read(7, 9, d, v);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL pix_ram got %h want 1", d); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_mm_read();
    test_circle_r3();
    test_wrap();
    test_mm_during_op();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
